// File: rtl/demux_1x2_skid_pkg.sv
// demux_1x2_skid_pkg: occupancy encoding and delivery counter width
package demux_1x2_skid_pkg;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
endpackage

// File: rtl/demux_1x2_skid_sat_counter.sv
// sat_counter: delivery counter that sticks at all-ones
module sat_counter
    import demux_1x2_skid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else if (inc && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
endmodule

// File: rtl/demux_1x2_skid.sv
// demux_1x2_skid: two-entry skid buffer routing each beat to Out1 or Out2 in order
module demux_1x2_skid
    import demux_1x2_skid_pkg::*;
#(
    parameter int n = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n-1:0]     In,
    input  logic             In_valid,
    input  logic             Choose,
    output logic             In_ready,
    output logic [n-1:0]     Out1,
    output logic [n-1:0]     Out2,
    output logic             Out1_valid,
    output logic             Out2_valid,
    input  logic             Out1_ready,
    input  logic             Out2_ready,
    output logic [CNT_W-1:0] Cnt1,
    output logic [CNT_W-1:0] Cnt2
);
    occ_t state, nxt;
    logic head_sel, skid_sel, accept, deliver;
    logic [n-1:0] head_data, skid_data;
    assign accept = In_valid & In_ready;
    assign deliver = (state != EMPTY) & (head_sel ? Out2_ready : Out1_ready);
    assign Out1_valid = (state != EMPTY) & ~head_sel;
    assign Out2_valid = (state != EMPTY) & head_sel;
    assign Out1 = head_data;
    assign Out2 = head_data;
    always_comb
        nxt = (state == EMPTY) ? (accept ? ONE : EMPTY) :
              (state == ONE)   ? ((accept && !deliver) ? TWO : (!accept && deliver) ? EMPTY : ONE) :
                                 (deliver ? ONE : TWO);
    always_ff @(posedge clk)
        if (!rst_n) begin
            state     <= EMPTY;
            In_ready  <= 1'b1;
            head_sel  <= 1'b0;
            head_data <= '0;
            skid_sel  <= 1'b0;
            skid_data <= '0;
        end else begin
            state    <= nxt;
            In_ready <= nxt != TWO;
            if (accept && (state == EMPTY || deliver)) {head_sel, head_data} <= {Choose, In};
            else if (state == TWO && deliver) {head_sel, head_data} <= {skid_sel, skid_data};
            if (accept && state == ONE && !deliver) {skid_sel, skid_data} <= {Choose, In};
        end
    sat_counter u_cnt1 (.clk(clk), .rst_n(rst_n), .inc(Out1_valid & Out1_ready), .cnt(Cnt1));
    sat_counter u_cnt2 (.clk(clk), .rst_n(rst_n), .inc(Out2_valid & Out2_ready), .cnt(Cnt2));
endmodule

// File: doc/demux_1x2_skid.md
DEMUX_1X2_SKID -- requirements
Module: demux_1x2_skid

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-004 The block SHALL have port In, input, n bits: upstream data.
REQ-005 The block SHALL have port In_valid, input, 1 bit: upstream offers In/Choose this cycle.
REQ-006 The block SHALL have port Choose, input, 1 bit: route select; 0 sends to Out1, 1 sends to Out2.
REQ-007 The block SHALL have port In_ready, output, 1 bit: block accepts the upstream beat this cycle.
REQ-008 The block SHALL have ports Out1 and Out2, output, n bits each: downstream data.
REQ-009 The block SHALL have ports Out1_valid and Out2_valid, output, 1 bit each: beat presented on that output.
REQ-010 The block SHALL have ports Out1_ready and Out2_ready, input, 1 bit each: downstream accepts.
REQ-011 The block SHALL have ports Cnt1 and Cnt2, output, 16 bits each: saturating count of beats delivered per output.

Function
REQ-012 A transfer SHALL occur on a port when its valid and ready are both high at a rising clk edge.
REQ-013 The block SHALL store up to 2 entries of {data, Choose}: a head register and a skid register.
REQ-014 Occupancy state SHALL be one of EMPTY, ONE, TWO; the skid register is only occupied in TWO.
REQ-015 In_ready SHALL be a registered output equal to (state != TWO); it SHALL NOT depend combinationally on Out1_ready/Out2_ready.
REQ-016 Only the head entry SHALL be presented: Outk_valid = (state != EMPTY) and head select selects k; the other output's valid SHALL be 0.
REQ-017 Out1 and Out2 SHALL both carry head data; the data value on the unselected output is don't-care.
REQ-018 The head entry's output SHALL remain stable (data, select, valid) until it transfers.
REQ-019 Transitions: EMPTY+accept -> ONE; ONE+accept only -> TWO; ONE+deliver only -> EMPTY; ONE+accept+deliver -> ONE with new head; TWO+deliver -> ONE, skid moves to head; otherwise hold.
REQ-020 Latency SHALL be 1 cycle: a beat accepted at edge t is presented at t+1 when EMPTY or when ONE with simultaneous delivery.
REQ-021 Sustained throughput SHALL be 1 beat/cycle while the selected consumer stays ready.
REQ-022 Order SHALL be preserved across both outputs; a blocked head SHALL stall later beats for the other output (head-of-line blocking is intended).
REQ-023 Cntk SHALL increment by 1 on each transfer on output k and hold at 16'hFFFF once reached.
REQ-024 The readiness of the unselected output SHALL have no effect on any state.

Reset
REQ-025 With rst_n low at a rising edge, state SHALL become EMPTY, In_ready 1, Out1_valid and Out2_valid 0, Cnt1 and Cnt2 0, and Out1/Out2 data 0.
REQ-026 Reset mid-operation SHALL discard both stored entries without delivering them; handshakes sampled in that cycle are ignored.
REQ-027 In_ready SHALL become 1 in the first cycle after reset is released.

Structure
REQ-028 Occupancy state encoding and the counter width (16) SHALL be defined as constants in the shared package.
REQ-029 The counter logic SHALL be one sub-module, sat_counter, instantiated twice.
REQ-030 The parameter n SHALL propagate to all data registers; no other parameter is required.

Verification
REQ-031 Stream: send A, B, C with Choose 0,1,0, both outputs always ready -> Out1 gets A at t+1, Out2 gets B at t+2, Out1 gets C at t+3; Cnt1=2 and Cnt2=1.
REQ-032 Backpressure: Out1_ready=0, send 0x11 then 0x22 (both Choose 0) -> state TWO and In_ready=0; set Out1_ready=1 -> 0x11 then 0x22 delivered in order, In_ready returns to 1.
REQ-033 Head-of-line blocking: head Choose 0 with Out1_ready=0 and next beat Choose 1 with Out2_ready=1 -> Out2_valid stays 0 until the head drains.
REQ-034 Reset mid-operation: in state TWO, drive rst_n=0 for one edge -> both valids 0, counts 0, In_ready 1; neither stored beat ever appears on an output.
REQ-035 Saturation: deliver 65 537 beats on Out2 -> Cnt2 holds at 0xFFFF and Cnt1 stays 0.
REQ-036 Random valid/ready stimulus with a scoreboard -> no loss, no duplication, correct routing, order preserved, and In_ready never low unless state is TWO.
